uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial 8N1 transmitter that sits directly downstream of the data sender. It takes one byte at a time and shifts it out on a single line, LSB first. It generates the `transmission_started` and `transmission_done` pulses that the data sender uses to step through its word. Bit timing comes from a fixed clock divider; there is no FIFO, and at most one frame is in flight.

## Interface
- `CLK_DIV`, default 104: clock cycles per serial bit; legal range ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  8  byte to transmit; sampled only on the accepting edge.
- `send`  in  1  level request; accepted only when idle.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high from acceptance until the frame completes.
- `transmission_started`  out  1  one-cycle pulse on the first cycle of the start bit.
- `transmission_done`  out  1  one-cycle pulse on the first idle cycle after the stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
  - Bit counter: 3 bits.
  - Divider counter: width $clog2(CLK_DIV), counts 0..CLK_DIV-1.
  - Shift register: 8 bits.
- Reset (synchronous) forces: state IDLE, `tx`=1, `busy`=0, both pulses 0, counters 0.
  - Applies mid-frame: the frame is abandoned, `tx` returns high at that edge, no `transmission_done` is emitted.
  - `rst` has priority over `send`.
- IDLE: `tx`=1, `busy`=0.
  - If `send`=1 at an edge: latch `data_in` into the shift register, go to START, clear the divider.
- START: `tx`=0 for CLK_DIV cycles, then go to DATA with the bit counter at 0.
- DATA: `tx` = shift register bit 0 for CLK_DIV cycles per bit.
  - At each bit end: shift right and increment the bit counter.
  - After bit 7: go to STOP.
- STOP: `tx`=1 for CLK_DIV cycles, then go to IDLE.
- `send` while not IDLE is ignored. Changes to `data_in` after acceptance do not affect the frame in flight.
- `send` held high continuously restarts a frame on every accepting opportunity (back-to-back frames).
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Let edge k be the edge that accepts `send` in IDLE.
- Cycle after edge k:
  - `tx`=0, `busy`=1, `transmission_started`=1.
  - The pulse lasts exactly 1 cycle.
- Start bit: cycles k+1 .. k+CLK_DIV.
- Data bit i (i=0..7): `tx` is valid from edge k+(1+i)·CLK_DIV for CLK_DIV cycles.
- Stop bit: from edge k+9·CLK_DIV for CLK_DIV cycles.
- At edge k+10·CLK_DIV:
  - State returns to IDLE: `busy`=0, `tx`=1.
  - `transmission_done`=1 for exactly 1 cycle.
- Total frame length on the line: 10·CLK_DIV cycles.
- `send` sampled at edge k+10·CLK_DIV is still in STOP and is ignored.
- Earliest next acceptance is edge k+10·CLK_DIV+1, i.e. the cycle in which `transmission_done` is high. Minimum frame-to-frame period is therefore 10·CLK_DIV+1 cycles.
- `transmission_started` and `transmission_done` are never high in the same cycle. Each frame produces exactly one of each, except frames cut short by reset, which produce no done.
- Upstream note: the data sender advances `dataOut` one edge after `transmission_done`. The controlling logic asserts `send` no earlier than the cycle after the done pulse to transmit the next byte.

## Test plan
- Reset → `tx`=1, `busy`=0, pulses 0. Hold for 20 cycles with `send`=0 → nothing changes.
- CLK_DIV=4, `data_in`=0x55, single-cycle `send`:
  - `transmission_started` is high for 1 cycle.
  - `tx` sequence per 4-cycle bit is 0,1,0,1,0,1,0,1,0,1.
  - `busy` is high for 40 cycles.
  - `transmission_done` pulses once at cycle 41 after acceptance.
- CLK_DIV=4, `data_in`=0xA3:
  - Sample `tx` at bit centres → 0, 1,1,0,0,0,1,0,1, 1.
  - Change `data_in` to 0xFF mid-frame → same waveform.
- `send` pulsed every cycle during a 0x0F frame → exactly one `transmission_started` and one `transmission_done`; the frame is unaltered.
- `send` held high with data 0x01 then 0x80 → two frames back-to-back with period 41 cycles (CLK_DIV=4). The second acceptance occurs in the done cycle.
- Assert `rst` during data bit 3 → `tx`=1 and `busy`=0 at the next edge, no `transmission_done`. A subsequent `send` of 0x5A transmits a clean full frame.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8N1 serial transmitter, LSB first, fixed clock divider per bit.
// Emits one-cycle started/done pulses that pace the upstream data sender.
module uart_transmitter #(
   parameter int CLK_DIV = 104
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       send,
   output logic       tx,
   output logic       busy,
   output logic       transmission_started,
   output logic       transmission_done
);

   localparam int DIV_W = $clog2(CLK_DIV);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t           r_state, w_state_nx;
   logic [DIV_W-1:0] r_div, w_div_nx;
   logic [2:0]       r_bit, w_bit_nx;
   logic [7:0]       r_shift, w_shift_nx;
   logic             r_tx, w_tx_nx;
   logic             r_busy, w_busy_nx;
   logic             r_started, w_started_nx;
   logic             r_done, w_done_nx;
   logic             w_div_end;

   assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));

   always_comb begin
      w_state_nx   = r_state;
      w_div_nx     = w_div_end ? '0 : r_div + 1'b1;
      w_bit_nx     = r_bit;
      w_shift_nx   = r_shift;
      w_started_nx = 1'b0;
      w_done_nx    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_div_nx = '0;
            if (send) begin
               w_shift_nx   = data_in;
               w_state_nx   = S_START;
               w_started_nx = 1'b1;
            end
         end
         S_START: begin
            if (w_div_end) begin
               w_state_nx = S_DATA;
               w_bit_nx   = '0;
            end
         end
         S_DATA: begin
            if (w_div_end) begin
               w_shift_nx = r_shift >> 1;
               w_bit_nx   = r_bit + 1'b1;
               if (r_bit == 3'd7) w_state_nx = S_STOP;
            end
         end
         S_STOP: begin
            if (w_div_end) begin
               w_state_nx = S_IDLE;
               w_done_nx  = 1'b1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase

      // Line level follows the state being entered so every output is a flop.
      case (w_state_nx)
         S_START: w_tx_nx = 1'b0;
         S_DATA:  w_tx_nx = w_shift_nx[0];
         default: w_tx_nx = 1'b1;
      endcase
      w_busy_nx = (w_state_nx != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_div     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_started <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_div     <= w_div_nx;
         r_bit     <= w_bit_nx;
         r_shift   <= w_shift_nx;
         r_tx      <= w_tx_nx;
         r_busy    <= w_busy_nx;
         r_started <= w_started_nx;
         r_done    <= w_done_nx;
      end
   end

   assign tx                   = r_tx;
   assign busy                 = r_busy;
   assign transmission_started = r_started;
   assign transmission_done    = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter at CLK_DIV=4: frame scoreboard plus corner-case sequences.
module tb_uart_transmitter;

   localparam int CD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       send = 1'b0;
   logic       tx, busy, transmission_started, transmission_done;

   uart_transmitter #(.CLK_DIV(CD)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .send(send),
      .tx(tx), .busy(busy),
      .transmission_started(transmission_started),
      .transmission_done(transmission_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   function automatic void chk(string nm, int act, int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Line-order frame image: [0]=start, [8:1]=data LSB first, [9]=stop
   typedef struct {
      logic [7:0] data;
      logic [9:0] line;
   } vec_t;

   logic [9:0] sb[$];
   int         cyc = 0;
   int         n_start = 0, n_done = 0;
   bit         overlap = 0;
   int         start_cyc[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (transmission_started) begin n_start++; start_cyc.push_back(cyc); end
      if (transmission_done) n_done++;
      if (transmission_started && transmission_done) overlap = 1;
   end

   // Frame monitor: t=0 is the first start-bit cycle; bits sampled at centres.
   bit         mon_active = 0;
   int         mon_t;
   logic [9:0] mon_bits;
   bit         mon_bad;
   logic [9:0] exp_line;

   always @(negedge clk) begin
      if (rst) begin
         if (mon_active) begin
            mon_active = 0;
            if (sb.size() > 0) void'(sb.pop_front());
         end
      end else if (!mon_active) begin
         if (transmission_started) begin
            mon_active = 1;
            mon_t      = 0;
            mon_bits   = '0;
            mon_bad    = !(tx === 1'b0 && busy === 1'b1 && transmission_done === 1'b0);
         end
      end else begin
         mon_t++;
         if (mon_t % CD == CD / 2 && mon_t < 10 * CD) mon_bits[mon_t / CD] = tx;
         if (mon_t < 10 * CD) begin
            if (busy !== 1'b1 || transmission_started !== 1'b0 || transmission_done !== 1'b0)
               mon_bad = 1;
         end else begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               exp_line = sb.pop_front();
               chk("frame_bits", int'(mon_bits), int'(exp_line));
            end
            chk("frame_ctl", int'(mon_bad), 0);
            chk("done_pulse", int'({transmission_done, busy, tx}), 3'b101);
            mon_active = 0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic [9:0] line);
      @(posedge clk); #1;
      data_in = d; send = 1'b1;
      sb.push_back(line);
      @(posedge clk); #1;
      send = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while ((busy || mon_active) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) chk("timeout", 0, 1);
   endtask

   vec_t vecs[4];

   initial begin
      int s0, d0;
      bit idle_bad;

      vecs[0] = '{8'h55, 10'h2AA};
      vecs[1] = '{8'h00, 10'h200};
      vecs[2] = '{8'hFF, 10'h3FE};
      vecs[3] = '{8'hA3, 10'h346};

      // Reset state, then quiet line with send low
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", int'({tx, busy, transmission_started, transmission_done}), 4'b1000);
      @(posedge clk); #1 rst = 1'b0;
      idle_bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || transmission_started || transmission_done) idle_bad = 1;
      end
      chk("idle_hold", int'(idle_bad), 0);

      // Table-driven single frames
      for (int i = 0; i < 4; i++) begin
         s0 = n_start; d0 = n_done;
         send_byte(vecs[i].data, vecs[i].line);
         wait_idle(200);
         chk("tbl_starts", n_start - s0, 1);
         chk("tbl_dones", n_done - d0, 1);
      end

      // data_in changes mid-frame must not alter the frame
      send_byte(8'hA3, 10'h346);
      repeat (10) @(posedge clk);
      #1 data_in = 8'hFF;
      wait_idle(200);

      // send asserted every cycle during a 0x0F frame
      s0 = n_start; d0 = n_done;
      @(posedge clk); #1;
      data_in = 8'h0F; send = 1'b1;
      sb.push_back(10'h21E);
      repeat (10 * CD) begin
         @(posedge clk); #1;
         data_in = 8'($urandom);
      end
      send = 1'b0;
      wait_idle(200);
      chk("spam_starts", n_start - s0, 1);
      chk("spam_dones", n_done - d0, 1);

      // send held high: back-to-back frames, second accepted in the done cycle
      start_cyc.delete();
      @(posedge clk); #1;
      data_in = 8'h01; send = 1'b1;
      sb.push_back(10'h202);
      @(posedge clk); #1;
      data_in = 8'h80;
      sb.push_back(10'h300);
      repeat (10 * CD + 1) @(posedge clk);
      #1 send = 1'b0;
      wait_idle(200);
      chk("b2b_count", start_cyc.size(), 2);
      if (start_cyc.size() == 2) chk("b2b_period", start_cyc[1] - start_cyc[0], 10 * CD + 1);

      // Reset during data bit 3 abandons the frame without a done pulse
      d0 = n_done;
      send_byte(8'h3C, 10'h278);
      repeat (4 * CD + 1) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_outs", int'({tx, busy}), 2'b10);
      repeat (60) @(negedge clk);
      chk("rst_no_done", n_done - d0, 0);
      chk("rst_sb_drop", sb.size(), 0);

      send_byte(8'h5A, 10'h2B4);
      wait_idle(200);
      chk("after_rst_done", n_done - d0, 1);

      chk("sb_empty", sb.size(), 0);
      chk("no_overlap", int'(overlap), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
